// File: rtl/mem_access_unit_if.sv
// Request/response handshake with the control FSM plus the valid/ack memory bus.
// The slave modport is the access unit; the master modport is the FSM/memory side.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_funct3, mem_ack, mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_funct3, mem_ack, mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store stage: alignment, byte enables, extension, valid/ack memory handshake.
// Latency accept+2 on zero-wait ack (errors accept+1); one request in flight, req_ready only in IDLE.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   mem_access_unit_if.slave  bus
);

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mem_cmd_t;

   state_t      state;
   mem_cmd_t    cmd_q;
   mem_cmd_t    cmd_next;
   logic        mem_req_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;
   logic [7:0]  tmo_cnt;
   logic [1:0]  lane_q;
   logic [2:0]  funct3_q;

   logic        funct3_legal;
   logic        misaligned;
   logic        req_ok;
   logic [31:0] rdata_shifted;
   logic [31:0] load_data;

   // Request decode works on the live request fields; it is only used on the accept cycle.
   always_comb begin
      funct3_legal = 1'b0;
      misaligned   = 1'b0;
      if (bus.req_write) begin
         funct3_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                        (bus.req_funct3 == 3'b010);
      end else begin
         funct3_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                        (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                        (bus.req_funct3 == 3'b101);
      end
      case (bus.req_funct3[1:0])
         2'b01:   misaligned = bus.req_addr[0];
         2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
      req_ok = funct3_legal && !misaligned;
   end

   always_comb begin
      cmd_next.we    = bus.req_write;
      cmd_next.addr  = {bus.req_addr[31:2], 2'b00};
      cmd_next.be    = 4'b1111;
      cmd_next.wdata = bus.req_wdata;
      if (bus.req_write) begin
         case (bus.req_funct3[1:0])
            2'b00: begin
               cmd_next.be    = 4'b0001 << bus.req_addr[1:0];
               cmd_next.wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
               cmd_next.be    = 4'b0011 << {bus.req_addr[1], 1'b0};
               cmd_next.wdata = {2{bus.req_wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata_shifted = bus.mem_rdata >> {lane_q, 3'b000};
      case (funct3_q)
         3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
         3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
         3'b100:  load_data = {24'h0, rdata_shifted[7:0]};
         3'b101:  load_data = {16'h0, rdata_shifted[15:0]};
         default: load_data = rdata_shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         cmd_q        <= '0;
         mem_req_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         tmo_cnt      <= '0;
         lane_q       <= '0;
         funct3_q     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               if (bus.req_valid) begin
                  tmo_cnt      <= '0;
                  lane_q       <= bus.req_addr[1:0];
                  funct3_q     <= bus.req_funct3;
                  resp_rdata_q <= '0;
                  if (req_ok) begin
                     cmd_q     <= cmd_next;
                     mem_req_q <= 1'b1;
                     state     <= S_WAIT;
                  end else begin
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     state        <= S_DONE;
                  end
               end
            end
            S_WAIT: begin
               // An ack on the limit cycle wins over the timeout.
               if (bus.mem_ack) begin
                  mem_req_q    <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= cmd_q.we ? 32'h0 : load_data;
                  state        <= S_DONE;
               end else if (tmo_cnt == TMO_LIMIT) begin
                  mem_req_q    <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= '0;
                  state        <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            S_DONE: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state == S_IDLE) && !reset;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = cmd_q.we;
   assign bus.mem_addr   = cmd_q.addr;
   assign bus.mem_be     = cmd_q.be;
   assign bus.mem_wdata  = cmd_q.wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: default-timeout instance (bus_a) and a 4-cycle-timeout instance (bus_b).
module tb_mem_access_unit;

   logic clk = 1'b0;
   logic reset;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   mem_access_unit_if bus_a ();
   mem_access_unit_if bus_b ();

   mem_access_unit u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   mem_access_unit #(.TIMEOUT_CYCLES(4)) u_dut_tmo (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a request for one cycle; returns in the cycle after acceptance.
   task automatic drive_a(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3);
      bus_a.req_valid  = 1'b1;
      bus_a.req_write  = w;
      bus_a.req_addr   = addr;
      bus_a.req_wdata  = wdata;
      bus_a.req_funct3 = f3;
      step();
      bus_a.req_valid  = 1'b0;
   endtask

   task automatic drive_b(input logic [31:0] addr, input logic [2:0] f3);
      bus_b.req_valid  = 1'b1;
      bus_b.req_write  = 1'b0;
      bus_b.req_addr   = addr;
      bus_b.req_wdata  = 32'h0;
      bus_b.req_funct3 = f3;
      step();
      bus_b.req_valid  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus_a.req_valid = 0; bus_a.req_write = 0; bus_a.req_addr = 0; bus_a.req_wdata = 0;
      bus_a.req_funct3 = 0; bus_a.mem_ack = 0; bus_a.mem_rdata = 0;
      bus_b.req_valid = 0; bus_b.req_write = 0; bus_b.req_addr = 0; bus_b.req_wdata = 0;
      bus_b.req_funct3 = 0; bus_b.mem_ack = 0; bus_b.mem_rdata = 0;
      step();
      step();
      total++; if (bus_a.req_ready !== 1'b0) $display("FAIL rst_req_ready got %b exp 0", bus_a.req_ready); else passed++;
      total++; if (bus_a.mem_req !== 1'b0) $display("FAIL rst_mem_req got %b exp 0", bus_a.mem_req); else passed++;
      total++; if (bus_a.mem_we !== 1'b0) $display("FAIL rst_mem_we got %b exp 0", bus_a.mem_we); else passed++;
      total++; if (bus_a.resp_valid !== 1'b0 || bus_a.resp_err !== 1'b0)
         $display("FAIL rst_resp got v=%b e=%b exp 0 0", bus_a.resp_valid, bus_a.resp_err); else passed++;
      total++; if (bus_a.mem_addr !== 32'h0 || bus_a.mem_be !== 4'h0 || bus_a.mem_wdata !== 32'h0 || bus_a.resp_rdata !== 32'h0)
         $display("FAIL rst_data got addr=%h be=%b wd=%h rd=%h exp all 0", bus_a.mem_addr, bus_a.mem_be,
                  bus_a.mem_wdata, bus_a.resp_rdata); else passed++;
      reset = 1'b0;
      #1;
      total++; if (bus_a.req_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", bus_a.req_ready); else passed++;
   endtask

   task automatic test_lw();
      total++; if (bus_a.req_ready !== 1'b1) $display("FAIL lw_ready got %b exp 1", bus_a.req_ready); else passed++;
      drive_a(1'b0, 32'h0000_0100, 32'h0, 3'b010);
      total++; if (bus_a.mem_req !== 1'b1 || bus_a.mem_we !== 1'b0)
         $display("FAIL lw_req got req=%b we=%b exp 1 0", bus_a.mem_req, bus_a.mem_we); else passed++;
      total++; if (bus_a.mem_addr !== 32'h100 || bus_a.mem_be !== 4'b1111)
         $display("FAIL lw_addr_be got %h %b exp 00000100 1111", bus_a.mem_addr, bus_a.mem_be); else passed++;
      total++; if (bus_a.resp_valid !== 1'b0) $display("FAIL lw_early_resp got %b exp 0", bus_a.resp_valid); else passed++;
      bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 32'hDEAD_BEEF;
      step();
      bus_a.mem_ack = 1'b0;
      total++; if (bus_a.resp_valid !== 1'b1 || bus_a.resp_err !== 1'b0 || bus_a.mem_req !== 1'b0)
         $display("FAIL lw_resp got v=%b e=%b req=%b exp 1 0 0", bus_a.resp_valid, bus_a.resp_err, bus_a.mem_req); else passed++;
      total++; if (bus_a.resp_rdata !== 32'hDEAD_BEEF) $display("FAIL lw_rdata got %h exp deadbeef", bus_a.resp_rdata); else passed++;
      total++; if (bus_a.req_ready !== 1'b0) $display("FAIL lw_done_ready got %b exp 0", bus_a.req_ready); else passed++;
      step();
      total++; if (bus_a.resp_valid !== 1'b0 || bus_a.req_ready !== 1'b1)
         $display("FAIL lw_after got v=%b rdy=%b exp 0 1", bus_a.resp_valid, bus_a.req_ready); else passed++;
   endtask

   task automatic test_load_ext();
      logic [31:0] addr [6] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200, 32'h200};
      logic [2:0]  f3   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
      logic [31:0] expv [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012, 32'h0000_8012,
                                32'h0000_0056, 32'h0000_3456};
      for (int i = 0; i < 6; i++) begin
         drive_a(1'b0, addr[i], 32'h0, f3[i]);
         total++; if (bus_a.mem_addr !== 32'h200 || bus_a.mem_be !== 4'b1111)
            $display("FAIL ext%0d_addr got %h %b exp 00000200 1111", i, bus_a.mem_addr, bus_a.mem_be); else passed++;
         bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 32'h8012_3456;
         step();
         bus_a.mem_ack = 1'b0;
         total++; if (bus_a.resp_valid !== 1'b1 || bus_a.resp_rdata !== expv[i])
            $display("FAIL ext%0d_rdata got v=%b %h exp 1 %h", i, bus_a.resp_valid, bus_a.resp_rdata, expv[i]); else passed++;
         step();
      end
   endtask

   task automatic test_store();
      logic [31:0] addr [4] = '{32'h102, 32'h101, 32'h104, 32'h103};
      logic [31:0] wd   [4] = '{32'h0000_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0000_00AB};
      logic [2:0]  f3   [4] = '{3'b001, 3'b000, 3'b010, 3'b000};
      logic [31:0] ea   [4] = '{32'h100, 32'h100, 32'h104, 32'h100};
      logic [3:0]  ebe  [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
      logic [31:0] ewd  [4] = '{32'hBEEF_BEEF, 32'h7878_7878, 32'hCAFE_F00D, 32'hABAB_ABAB};
      for (int i = 0; i < 4; i++) begin
         drive_a(1'b1, addr[i], wd[i], f3[i]);
         total++; if (bus_a.mem_req !== 1'b1 || bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== ea[i])
            $display("FAIL st%0d_req got req=%b we=%b addr=%h exp 1 1 %h", i, bus_a.mem_req, bus_a.mem_we,
                     bus_a.mem_addr, ea[i]); else passed++;
         total++; if (bus_a.mem_be !== ebe[i] || bus_a.mem_wdata !== ewd[i])
            $display("FAIL st%0d_lanes got be=%b wd=%h exp %b %h", i, bus_a.mem_be, bus_a.mem_wdata, ebe[i], ewd[i]); else passed++;
         bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 32'h5555_5555;
         step();
         bus_a.mem_ack = 1'b0;
         total++; if (bus_a.resp_valid !== 1'b1 || bus_a.resp_err !== 1'b0 || bus_a.resp_rdata !== 32'h0)
            $display("FAIL st%0d_resp got v=%b e=%b rd=%h exp 1 0 0", i, bus_a.resp_valid, bus_a.resp_err, bus_a.resp_rdata); else passed++;
         step();
      end
   endtask

   task automatic test_errors();
      logic        w    [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] addr [6] = '{32'h101, 32'h100, 32'h102, 32'h100, 32'h102, 32'h100};
      logic [2:0]  f3   [6] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b010, 3'b110};
      for (int i = 0; i < 6; i++) begin
         drive_a(w[i], addr[i], 32'hFFFF_FFFF, f3[i]);
         total++; if (bus_a.mem_req !== 1'b0 || bus_a.resp_valid !== 1'b1 || bus_a.resp_err !== 1'b1)
            $display("FAIL err%0d_resp got req=%b v=%b e=%b exp 0 1 1", i, bus_a.mem_req, bus_a.resp_valid, bus_a.resp_err); else passed++;
         total++; if (bus_a.resp_rdata !== 32'h0) $display("FAIL err%0d_rdata got %h exp 0", i, bus_a.resp_rdata); else passed++;
         step();
         total++; if (bus_a.resp_valid !== 1'b0 || bus_a.resp_err !== 1'b0 || bus_a.req_ready !== 1'b1)
            $display("FAIL err%0d_after got v=%b e=%b rdy=%b exp 0 0 1", i, bus_a.resp_valid, bus_a.resp_err, bus_a.req_ready); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      // A stray ack while idle must not produce a response.
      bus_a.mem_ack = 1'b1;
      step();
      bus_a.mem_ack = 1'b0;
      total++; if (bus_a.resp_valid !== 1'b0 || bus_a.mem_req !== 1'b0)
         $display("FAIL idle_ack got v=%b req=%b exp 0 0", bus_a.resp_valid, bus_a.mem_req); else passed++;
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b0; bus_a.req_addr = 32'h200; bus_a.req_funct3 = 3'b010;
      step();
      bus_a.req_addr = 32'h300;
      total++; if (bus_a.mem_addr !== 32'h200) $display("FAIL b2b_resample got %h exp 00000200", bus_a.mem_addr); else passed++;
      bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 32'h1111_1111;
      step();
      bus_a.mem_ack = 1'b0;
      total++; if (bus_a.resp_valid !== 1'b1 || bus_a.req_ready !== 1'b0 || bus_a.resp_rdata !== 32'h1111_1111)
         $display("FAIL b2b_done got v=%b rdy=%b rd=%h exp 1 0 11111111", bus_a.resp_valid, bus_a.req_ready,
                  bus_a.resp_rdata); else passed++;
      step();
      total++; if (bus_a.req_ready !== 1'b1 || bus_a.mem_req !== 1'b0 || bus_a.resp_valid !== 1'b0)
         $display("FAIL b2b_idle got rdy=%b req=%b v=%b exp 1 0 0", bus_a.req_ready, bus_a.mem_req, bus_a.resp_valid); else passed++;
      step();
      bus_a.req_valid = 1'b0;
      total++; if (bus_a.mem_req !== 1'b1 || bus_a.mem_addr !== 32'h300)
         $display("FAIL b2b_second got req=%b addr=%h exp 1 00000300", bus_a.mem_req, bus_a.mem_addr); else passed++;
      bus_a.mem_ack = 1'b1;
      step();
      bus_a.mem_ack = 1'b0;
      step();
   endtask

   task automatic test_wait_states();
      drive_a(1'b1, 32'h10A, 32'h0000_A5C3, 3'b001);
      for (int i = 0; i < 5; i++) begin
         total++; if (bus_a.mem_req !== 1'b1 || bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== 32'h108 ||
                      bus_a.mem_be !== 4'b1100 || bus_a.mem_wdata !== 32'hA5C3_A5C3 || bus_a.resp_valid !== 1'b0)
            $display("FAIL wait%0d_hold got req=%b we=%b addr=%h be=%b wd=%h v=%b exp 1 1 00000108 1100 a5c3a5c3 0", i,
                     bus_a.mem_req, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_be, bus_a.mem_wdata, bus_a.resp_valid); else passed++;
         step();
      end
      total++; if (bus_a.mem_req !== 1'b1) $display("FAIL wait_sixth got %b exp 1", bus_a.mem_req); else passed++;
      bus_a.mem_ack = 1'b1;
      step();
      bus_a.mem_ack = 1'b0;
      total++; if (bus_a.mem_req !== 1'b0 || bus_a.resp_valid !== 1'b1 || bus_a.resp_err !== 1'b0)
         $display("FAIL wait_resp got req=%b v=%b e=%b exp 0 1 0", bus_a.mem_req, bus_a.resp_valid, bus_a.resp_err); else passed++;
      step();
   endtask

   task automatic test_timeout();
      drive_b(32'h400, 3'b010);
      for (int i = 0; i < 5; i++) begin
         total++; if (bus_b.mem_req !== 1'b1 || bus_b.resp_valid !== 1'b0)
            $display("FAIL tmo%0d_hold got req=%b v=%b exp 1 0", i, bus_b.mem_req, bus_b.resp_valid); else passed++;
         step();
      end
      total++; if (bus_b.mem_req !== 1'b0 || bus_b.resp_valid !== 1'b1 || bus_b.resp_err !== 1'b1 || bus_b.resp_rdata !== 32'h0)
         $display("FAIL tmo_abort got req=%b v=%b e=%b rd=%h exp 0 1 1 0", bus_b.mem_req, bus_b.resp_valid,
                  bus_b.resp_err, bus_b.resp_rdata); else passed++;
      step();
      total++; if (bus_b.resp_valid !== 1'b0 || bus_b.req_ready !== 1'b1)
         $display("FAIL tmo_after got v=%b rdy=%b exp 0 1", bus_b.resp_valid, bus_b.req_ready); else passed++;
      // Ack on the limit cycle completes normally.
      drive_b(32'h404, 3'b101);
      for (int i = 0; i < 4; i++) step();
      total++; if (bus_b.mem_req !== 1'b1) $display("FAIL tmo_limit_req got %b exp 1", bus_b.mem_req); else passed++;
      bus_b.mem_ack = 1'b1; bus_b.mem_rdata = 32'h9ABC_0000;
      step();
      bus_b.mem_ack = 1'b0;
      total++; if (bus_b.resp_valid !== 1'b1 || bus_b.resp_err !== 1'b0 || bus_b.resp_rdata !== 32'h0000_0000)
         $display("FAIL tmo_limit_ack got v=%b e=%b rd=%h exp 1 0 0", bus_b.resp_valid, bus_b.resp_err, bus_b.resp_rdata); else passed++;
      step();
   endtask

   task automatic test_reset_mid_wait();
      drive_a(1'b0, 32'h500, 32'h0, 3'b010);
      total++; if (bus_a.mem_req !== 1'b1) $display("FAIL rmw_req got %b exp 1", bus_a.mem_req); else passed++;
      reset = 1'b1;
      step();
      total++; if (bus_a.mem_req !== 1'b0 || bus_a.resp_valid !== 1'b0 || bus_a.req_ready !== 1'b0)
         $display("FAIL rmw_reset got req=%b v=%b rdy=%b exp 0 0 0", bus_a.mem_req, bus_a.resp_valid, bus_a.req_ready); else passed++;
      reset = 1'b0;
      bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 32'h7777_7777;
      #1;
      total++; if (bus_a.req_ready !== 1'b1) $display("FAIL rmw_ready got %b exp 1", bus_a.req_ready); else passed++;
      step();
      bus_a.mem_ack = 1'b0;
      total++; if (bus_a.resp_valid !== 1'b0 || bus_a.mem_req !== 1'b0)
         $display("FAIL rmw_late_ack got v=%b req=%b exp 0 0", bus_a.resp_valid, bus_a.mem_req); else passed++;
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_ext();
      test_store();
      test_errors();
      test_back_to_back();
      test_wait_states();
      test_timeout();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
